// File: rtl/mips_pkg.sv
// Shared pipeline definitions: register-address width, forwarding-mux select
// encodings and the per-stage hazard tracking slot.
package mips_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
        logic                  mem_read;
    } slot_t;

    // Register $0 is hard-wired to zero, so a write to it produces nothing to forward.
    function automatic logic is_writer(slot_t s);
        return s.valid && s.reg_write && (s.dest != '0);
    endfunction

    function automatic logic produces(slot_t s, logic [REG_ADDR_W-1:0] src);
        return is_writer(s) && (s.dest == src);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding select for one ALU operand: the youngest in-flight producer of
// the source register wins, otherwise the register-file value is used.
module fwd_select
    import mips_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  uses,
    input  slot_t                 ex_slot,
    input  slot_t                 mem_slot,
    output fwd_sel_e              sel
);

    always_comb begin
        // NOTE: default assignment first so every path drives sel and no latch is inferred.
        sel = FWD_RF;
        if (uses) begin
            if (produces(ex_slot, src)) begin
                sel = FWD_EXMEM;
            end else if (produces(mem_slot, src)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use stall and EX-stage operand forwarding control for the 5-stage MIPS
// pipeline, plus a saturating count of stall cycles.
module hazard_fwd_unit
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    output logic                  stall,
    output logic                  ex_flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_cnt
);

    // The WB-stage instruction needs no slot: the register file writes in the
    // first half-cycle, so ID already reads its result.
    slot_t    ex_slot;
    slot_t    mem_slot;
    slot_t    id_slot;
    fwd_sel_e a_next;
    fwd_sel_e b_next;
    logic     load_use;

    assign id_slot = '{valid: id_valid, dest: id_dest,
                       reg_write: id_reg_write, mem_read: id_mem_read};

    assign load_use = id_valid && is_writer(ex_slot) && ex_slot.mem_read &&
                      ((id_uses_rs && (id_rs == ex_slot.dest)) ||
                       (id_uses_rt && (id_rt == ex_slot.dest)));

    // Gated by rst_n so an asserted reset drops the stall without waiting for the slots to clear.
    assign stall    = rst_n && load_use;
    assign ex_flush = stall;

    fwd_select u_sel_a (
        .src      (id_rs),
        .uses     (id_uses_rs),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .sel      (a_next)
    );

    fwd_select u_sel_b (
        .src      (id_rt),
        .uses     (id_uses_rt),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .sel      (b_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values (mem_slot takes the old ex_slot).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot   <= '0;
            mem_slot  <= '0;
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
            stall_cnt <= '0;
        end else begin
            mem_slot <= ex_slot;
            if (stall) begin
                ex_slot <= '0;
            end else begin
                ex_slot <= id_slot;
            end

            if (stall || !id_valid) begin
                fwd_a_sel <= FWD_RF;
                fwd_b_sel <= FWD_RF;
            end else begin
                fwd_a_sel <= a_next;
                fwd_b_sel <= b_next;
            end

            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed, table-driven bench for hazard_fwd_unit: one record per pipeline
// cycle with the ID instruction and the outputs expected in that cycle.
module tb_hazard_fwd_unit;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  id_dest;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        stall;
    logic        ex_flush;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    hazard_fwd_unit #(.CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .stall        (stall),
        .ex_flush     (ex_flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dest;
        logic       rw;
        logic       mr;
        logic       st;
        logic [1:0] a;
        logic [1:0] b;
        int         cnt;
    } vec_t;

    function automatic vec_t mk(logic v, int rs, int rt, logic urs, logic urt,
                                int dest, logic rw, logic mr,
                                logic st, int a, int b, int cnt);
        vec_t r;
        r.v = v;     r.rs = rs[4:0]; r.rt = rt[4:0];
        r.urs = urs; r.urt = urt;    r.dest = dest[4:0];
        r.rw = rw;   r.mr = mr;      r.st = st;
        r.a = a[1:0]; r.b = b[1:0];  r.cnt = cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid     = v.v;
        id_rs        = v.rs;
        id_rt        = v.rt;
        id_uses_rs   = v.urs;
        id_uses_rt   = v.urt;
        id_dest      = v.dest;
        id_reg_write = v.rw;
        id_mem_read  = v.mr;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        check({tag, "_stall"}, 32'(stall), 32'(v.st));
        check({tag, "_flush"}, 32'(ex_flush), 32'(v.st));
        check({tag, "_fwd_a"}, 32'(fwd_a_sel), 32'(v.a));
        check({tag, "_fwd_b"}, 32'(fwd_b_sel), 32'(v.b));
        check({tag, "_cnt"}, 32'(stall_cnt), 32'(v.cnt));
    endtask

    // One pipeline cycle: present the ID instruction after the edge, check mid-cycle.
    task automatic run(input string tag, input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        check_outs(tag, v);
    endtask

    vec_t vecs[25];
    vec_t tail[3];
    vec_t nop;

    initial begin
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // add $3,$1,$2 ; sub $4,$3,$5
        vecs[0]  = mk(1, 1, 2, 1, 1, 3, 1, 0,  0, 0, 0, 0);
        vecs[1]  = mk(1, 3, 5, 1, 1, 4, 1, 0,  0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
        // add $3 ; and $8,$9,$10 ; or $6,$7,$3
        vecs[3]  = mk(1, 1, 2, 1, 1, 3, 1, 0,  0, 0, 0, 0);
        vecs[4]  = mk(1, 9, 10, 1, 1, 8, 1, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 7, 3, 1, 1, 6, 1, 0,  0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0);
        // add $3 ; addi $3,$4 ; add $10,$3,$3  (EX and MEM both write $3)
        vecs[7]  = mk(1, 1, 2, 1, 1, 3, 1, 0,  0, 0, 0, 0);
        vecs[8]  = mk(1, 4, 0, 1, 0, 3, 1, 0,  0, 0, 0, 0);
        vecs[9]  = mk(1, 3, 3, 1, 1, 10, 1, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0);
        // lw $5,0($1) ; add $6,$2,$5 (held one cycle)
        vecs[11] = mk(1, 1, 5, 1, 0, 5, 1, 1,  0, 0, 0, 0);
        vecs[12] = mk(1, 2, 5, 1, 1, 6, 1, 0,  1, 0, 0, 0);
        vecs[13] = mk(1, 2, 5, 1, 1, 6, 1, 0,  0, 0, 0, 1);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 1);
        // lw $0 ; add $0,$0,$0 ; sub $9,$0,$0
        vecs[15] = mk(1, 1, 0, 1, 0, 0, 1, 1,  0, 0, 0, 1);
        vecs[16] = mk(1, 0, 0, 1, 1, 0, 1, 0,  0, 0, 0, 1);
        vecs[17] = mk(1, 0, 0, 1, 1, 9, 1, 0,  0, 0, 0, 1);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        // lw $5 ; lw $6,0($5) ; add $7,$6,$2  (chained loads)
        vecs[19] = mk(1, 1, 5, 1, 0, 5, 1, 1,  0, 0, 0, 1);
        vecs[20] = mk(1, 5, 6, 1, 0, 6, 1, 1,  1, 0, 0, 1);
        vecs[21] = mk(1, 5, 6, 1, 0, 6, 1, 1,  0, 0, 0, 2);
        vecs[22] = mk(1, 6, 2, 1, 1, 7, 1, 0,  1, 2, 0, 2);
        vecs[23] = mk(1, 6, 2, 1, 1, 7, 1, 0,  0, 0, 0, 3);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 3);
        // After reset: add $3,$1,$2 ; sub $4,$3,$5
        tail[0]  = mk(1, 1, 2, 1, 1, 3, 1, 0,  0, 0, 0, 0);
        tail[1]  = mk(1, 3, 5, 1, 1, 4, 1, 0,  0, 0, 0, 0);
        tail[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);

        // Reset state, with an ID instruction present that must not stall.
        rst_n = 1'b0;
        drive(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0));
        #3;
        check_outs("reset", nop);
        drive(nop);
        #9;
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            run($sformatf("v%0d", i), vecs[i]);
        end

        // Reset asserted mid-stall clears everything without a clock edge.
        run("r0", mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 3));
        run("r1", mk(1, 3, 5, 1, 0, 5, 1, 1, 0, 0, 0, 3));
        @(posedge clk);
        #1;
        drive(mk(1, 2, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0));
        #1;
        check_outs("r2_pre", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3));
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("r2_rst", nop);
        drive(nop);
        @(negedge clk);
        check_outs("r2_hold", nop);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            run($sformatf("t%0d", i), tail[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
